// File: rtl/stream_fifo_sync_if.sv
// Single valid/ready stream link. The producer side uses master and the consumer side uses slave.
interface stream_fifo_sync_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/stream_fifo_sync.sv
// Synchronous valid/ready FIFO that sits downstream of the stream arbiter.
// It has an optional combinational fall-through path for when it is empty.
module stream_fifo_sync #(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned DEPTH        = 4,
    parameter bit          FALL_THROUGH = 1'b0,
    localparam int unsigned ADDR_W      = $clog2(DEPTH)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    stream_fifo_sync_if.slave    inp,
    stream_fifo_sync_if.master   oup,
    output logic [ADDR_W:0]      usage_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    if (DEPTH < 2) begin : g_depth_check
        $error("stream_fifo_sync: DEPTH must be >= 2");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0]     wptr_q, wptr_d;
    logic [ADDR_W-1:0]     rptr_q, rptr_d;
    logic [ADDR_W:0]       usage_q, usage_d;

    logic bypass_c;
    logic push_c;
    logic pop_c;
    logic write_c;
    logic read_c;

    function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + ADDR_W'(1);
    endfunction

    assign full_o  = (usage_q == DEPTH_CNT);
    assign empty_o = (usage_q == '0);
    assign usage_o = usage_q;

    // inp.ready never depends on oup.ready: a full FIFO refuses a push even on a pop cycle.
    assign inp.ready = !full_o && !flush_i;
    assign bypass_c  = FALL_THROUGH && empty_o && inp.valid && !flush_i;
    assign oup.valid = !empty_o || bypass_c;
    assign oup.data  = bypass_c ? inp.data : mem_q[rptr_q];

    assign push_c  = inp.valid && inp.ready;
    assign pop_c   = oup.valid && oup.ready;
    // A bypassed word that is consumed at once never touches storage.
    assign write_c = push_c && !(bypass_c && oup.ready);
    assign read_c  = pop_c && !bypass_c;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        usage_d = usage_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            usage_d = '0;
        end else begin
            if (write_c) wptr_d = next_ptr(wptr_q);
            if (read_c)  rptr_d = next_ptr(rptr_q);
            case ({write_c, read_c})
                2'b10:   usage_d = usage_q + (ADDR_W + 1)'(1);
                2'b01:   usage_d = usage_q - (ADDR_W + 1)'(1);
                default: usage_d = usage_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            usage_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            usage_q <= usage_d;
        end
    end

    // Storage is intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && write_c) mem_q[wptr_q] <= inp.data;
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push_c && full_o));
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (rst_i) !(read_c && empty_o));
    a_usage_bound:  assert property (@(posedge clk_i) disable iff (rst_i) usage_q <= DEPTH_CNT);

endmodule

// File: tb/tb_stream_fifo_sync.sv
// Scoreboard bench for stream_fifo_sync with three configurations:
// DEPTH=4 registered, DEPTH=3 registered, and DEPTH=4 fall-through.
module tb_stream_fifo_sync;

    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] qa[$];
    logic [DW-1:0] qb[$];
    logic [DW-1:0] qc[$];

    stream_fifo_sync_if #(.DATA_WIDTH(DW)) a_in(), a_out(), b_in(), b_out(), c_in(), c_out();
    logic       a_flush = 1'b0, b_flush = 1'b0, c_flush = 1'b0;
    logic [2:0] a_usage, b_usage, c_usage;
    logic       a_full, a_empty, b_full, b_empty, c_full, c_empty;

    stream_fifo_sync #(.DATA_WIDTH(DW), .DEPTH(4), .FALL_THROUGH(1'b0)) u_a (
        .clk_i(clk), .rst_i(rst), .flush_i(a_flush), .inp(a_in), .oup(a_out),
        .usage_o(a_usage), .full_o(a_full), .empty_o(a_empty));
    stream_fifo_sync #(.DATA_WIDTH(DW), .DEPTH(3), .FALL_THROUGH(1'b0)) u_b (
        .clk_i(clk), .rst_i(rst), .flush_i(b_flush), .inp(b_in), .oup(b_out),
        .usage_o(b_usage), .full_o(b_full), .empty_o(b_empty));
    stream_fifo_sync #(.DATA_WIDTH(DW), .DEPTH(4), .FALL_THROUGH(1'b1)) u_c (
        .clk_i(clk), .rst_i(rst), .flush_i(c_flush), .inp(c_in), .oup(c_out),
        .usage_o(c_usage), .full_o(c_full), .empty_o(c_empty));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Output monitors: every handshake must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && a_out.valid && a_out.ready) begin
            if (qa.size() == 0) begin
                checks++; errors++;
                $display("FAIL a_unexpected: got 0x%0h with empty scoreboard", a_out.data);
            end else chk("a_data", 32'(a_out.data), 32'(qa.pop_front()));
        end
        if (!rst && b_out.valid && b_out.ready) begin
            if (qb.size() == 0) begin
                checks++; errors++;
                $display("FAIL b_unexpected: got 0x%0h with empty scoreboard", b_out.data);
            end else chk("b_data", 32'(b_out.data), 32'(qb.pop_front()));
        end
        if (!rst && c_out.valid && c_out.ready) begin
            if (qc.size() == 0) begin
                checks++; errors++;
                $display("FAIL c_unexpected: got 0x%0h with empty scoreboard", c_out.data);
            end else chk("c_data", 32'(c_out.data), 32'(qc.pop_front()));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        int cyc;
        logic acc;

        a_in.valid = 1'b1; a_in.data = 8'h99; a_out.ready = 1'b0;
        b_in.valid = 1'b1; b_in.data = 8'h99; b_out.ready = 1'b0;
        c_in.valid = 1'b0; c_in.data = 8'h00; c_out.ready = 1'b0;

        // Reset held two cycles while input is valid
        step();
        step();
        chk("rst_usage_during", 32'(a_usage), 0);
        rst = 1'b0;
        a_in.valid = 1'b0;
        b_in.valid = 1'b0;
        step();
        chk("rst_valid", 32'(a_out.valid), 0);
        chk("rst_usage", 32'(a_usage), 0);
        chk("rst_empty", 32'(a_empty), 1);
        chk("rst_full", 32'(a_full), 0);
        chk("rst_ready", 32'(a_in.ready), 1);

        // Fill and drain, DEPTH=4
        for (int k = 0; k < 4; k++) begin
            qa.push_back(8'hA0 + 8'(k));
            a_in.valid = 1'b1;
            a_in.data  = 8'hA0 + 8'(k);
            step();
            chk("fill_usage", 32'(a_usage), 32'(k + 1));
            chk("fill_valid", 32'(a_out.valid), 1);
        end
        chk("full_flag", 32'(a_full), 1);
        chk("full_ready", 32'(a_in.ready), 0);
        a_in.data = 8'hBB;
        step();
        chk("full_no_push", 32'(a_usage), 4);
        a_in.valid = 1'b0;
        a_out.ready = 1'b1;
        repeat (4) step();
        a_out.ready = 1'b0;
        chk("drain_empty", 32'(a_empty), 1);
        chk("drain_usage", 32'(a_usage), 0);
        chk("drain_sb", 32'(qa.size()), 0);

        // Back-pressure keeps the head stable
        qa.push_back(8'h55);
        qa.push_back(8'h66);
        a_in.valid = 1'b1; a_in.data = 8'h55;
        step();
        a_in.data = 8'h66;
        step();
        a_in.valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("bp_data", 32'(a_out.data), 32'h55);
            chk("bp_valid", 32'(a_out.valid), 1);
            step();
        end
        a_out.ready = 1'b1;
        step();
        chk("bp_next", 32'(a_out.data), 32'h66);
        step();
        a_out.ready = 1'b0;
        chk("bp_empty", 32'(a_empty), 1);

        // Simultaneous push and pop with a single entry stored
        qa.push_back(8'h11);
        qa.push_back(8'h22);
        a_in.valid = 1'b1; a_in.data = 8'h11;
        step();
        a_in.data = 8'h22; a_out.ready = 1'b1;
        step();
        a_in.valid = 1'b0; a_out.ready = 1'b0;
        chk("pp_usage", 32'(a_usage), 1);
        chk("pp_valid", 32'(a_out.valid), 1);
        chk("pp_data", 32'(a_out.data), 32'h22);
        a_out.ready = 1'b1;
        step();
        a_out.ready = 1'b0;

        // Flush three stored words; they must never emerge
        for (int k = 0; k < 3; k++) begin
            a_in.valid = 1'b1;
            a_in.data  = 8'hF1 + 8'(k);
            step();
        end
        chk("fl_usage_pre", 32'(a_usage), 3);
        a_flush = 1'b1; a_in.data = 8'hF4;
        #1;
        chk("fl_ready", 32'(a_in.ready), 0);
        chk("fl_valid_same", 32'(a_out.valid), 1);
        step();
        a_flush = 1'b0; a_in.valid = 1'b0;
        chk("fl_usage", 32'(a_usage), 0);
        chk("fl_valid", 32'(a_out.valid), 0);
        chk("fl_empty", 32'(a_empty), 1);
        qa.push_back(8'hEE);
        a_in.valid = 1'b1; a_in.data = 8'hEE; a_out.ready = 1'b1;
        step();
        a_in.valid = 1'b0;
        step();
        a_out.ready = 1'b0;
        chk("fl_sb", 32'(qa.size()), 0);

        // Wrap-around, DEPTH=3, output ready toggling
        for (int k = 0; k < 10; k++) qb.push_back(8'(k));
        i = 0;
        cyc = 0;
        while ((i < 10 || qb.size() != 0) && cyc < 200) begin
            b_out.ready = (cyc % 2 == 0);
            b_in.valid  = (i < 10);
            b_in.data   = 8'(i);
            @(negedge clk);
            chk("wrap_usage_le3", 32'(b_usage <= 3'd3), 1);
            acc = b_in.valid && b_in.ready;
            step();
            if (acc) i++;
            cyc++;
        end
        b_in.valid = 1'b0; b_out.ready = 1'b0;
        chk("wrap_done", 32'(cyc < 200), 1);
        chk("wrap_sb", 32'(qb.size()), 0);

        // Fall-through: an empty FIFO forwards in the same cycle
        qc.push_back(8'h7E);
        c_in.valid = 1'b1; c_in.data = 8'h7E; c_out.ready = 1'b1;
        #1;
        chk("ft_valid", 32'(c_out.valid), 1);
        chk("ft_data", 32'(c_out.data), 32'h7E);
        chk("ft_usage_same", 32'(c_usage), 0);
        step();
        c_in.valid = 1'b0; c_out.ready = 1'b0;
        chk("ft_usage", 32'(c_usage), 0);
        chk("ft_empty", 32'(c_empty), 1);
        qc.push_back(8'h3C);
        c_in.valid = 1'b1; c_in.data = 8'h3C;
        #1;
        chk("ft_bp_data", 32'(c_out.data), 32'h3C);
        step();
        c_in.valid = 1'b0;
        chk("ft_bp_usage", 32'(c_usage), 1);
        chk("ft_bp_hold", 32'(c_out.data), 32'h3C);
        c_out.ready = 1'b1;
        step();
        c_out.ready = 1'b0;
        chk("ft_sb", 32'(qc.size()), 0);
        chk("ft_final_empty", 32'(c_empty), 1);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_fifo_sync.md
Name: stream_fifo_sync

Overview:
- Parametrizable-depth valid/ready FIFO placed directly downstream of the stream arbiter.
- Decouples the arbitrated output stream from the consuming unit (e.g. a shared memory port or bus master).
- Absorbs back-pressure bursts so the arbiter can keep granting inputs.
- Preserves stream rules: once oup_valid_o is high, oup_data_o stays stable until the handshake.

Parameters:
- DATA_WIDTH, 32, width of each data word in bits (>=1).
- DEPTH, 4, number of storage entries (>=2; need not be a power of two).
- FALL_THROUGH, 0, 1 = an empty FIFO forwards input to output combinationally in the same cycle; 0 = registered, minimum latency 1 cycle.
- ADDR_W, $clog2(DEPTH), derived pointer width; not overridden.

Ports:
- clk_i  input  1  clock
- rst_i  input  1  reset
- flush_i  input  1  discard all stored entries
- inp_data_i  input  DATA_WIDTH  input word (from arbiter oup_data_o)
- inp_valid_i  input  1  input valid
- inp_ready_o  output  1  input ready
- oup_data_o  output  DATA_WIDTH  head-of-FIFO word
- oup_valid_o  output  1  output valid
- oup_ready_i  input  1  output ready
- usage_o  output  ADDR_W+1  current number of stored entries
- full_o  output  1  usage_o == DEPTH
- empty_o  output  1  usage_o == 0

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock is clk_i, reset is rst_i. All state updates on the rising edge of clk_i.
- Reset (rst_i=1 at an edge):
  - read/write pointers = 0, usage_o = 0, empty_o = 1, full_o = 0, oup_valid_o = 0.
  - Storage contents are not reset. oup_data_o is don't-care while oup_valid_o = 0.
  - Reset wins over every other input in that cycle. A transfer in flight mid-reset is dropped.
- Push: inp_valid_i & inp_ready_o.
  - Write entry at wptr; wptr increments, wrapping from DEPTH-1 to 0.
- Pop: oup_valid_o & oup_ready_i.
  - rptr increments with the same wrap rule.
- inp_ready_o = !full_o & !flush_i.
  - No push into a full FIFO, even if a pop occurs in the same cycle. This keeps ready free of combinational paths from oup_ready_i.
- oup_valid_o = !empty_o, or (FALL_THROUGH & empty_o & inp_valid_i & !flush_i).
- oup_data_o = mem[rptr], or inp_data_i when the fall-through path is active.
- Fall-through with an empty FIFO and simultaneous oup_ready_i: the word bypasses storage. Pointers and usage are unchanged.
- usage update:
  - +1 on push only; -1 on pop only; unchanged on push+pop in the same cycle.
  - Width ADDR_W+1 so the value DEPTH is representable.
- Simultaneous push and pop at usage == 1 (FALL_THROUGH=0): the head is popped and the new word is stored. Next cycle oup_valid_o = 1 with the new word.
- Latency, FALL_THROUGH=0: a word pushed at edge N is visible on oup_data_o/oup_valid_o after edge N (one cycle).
- Flush (flush_i=1):
  - Same cycle: inp_ready_o = 0. oup_valid_o is driven by the stored state; any pop handshake in that cycle is still honoured.
  - At the edge: pointers and usage cleared to 0; next cycle empty_o = 1.
  - flush_i with rst_i: reset dominates, with identical effect.
- Data stability: while oup_valid_o = 1 and oup_ready_i = 0, oup_data_o and oup_valid_o do not change (flush excepted).
- Assertions (simulation only):
  - No push when full.
  - No pop when empty, excluding fall-through.
  - usage_o <= DEPTH.
  - DEPTH >= 2 at elaboration.

Test Plan:
- Reset, FALL_THROUGH=0: hold rst_i=1 two cycles with inp_valid_i=1 → oup_valid_o=0, usage_o=0, empty_o=1, inp_ready_o=1 one cycle after release.
- Fill/drain, DEPTH=4: push 0xA0..0xA3 with oup_ready_i=0 → full_o=1, inp_ready_o=0, usage_o=4. Then oup_ready_i=1 → outputs 0xA0,0xA1,0xA2,0xA3 in order, empty_o=1 afterwards.
- Wrap-around, DEPTH=3: stream 10 words 0..9 with oup_ready_i toggling 1,0,1,0 → all 10 words emerge in order, no loss or duplication, usage_o never >3.
- Back-pressure stability: push 0x55, hold oup_ready_i=0 for 5 cycles while pushing 0x66 → oup_data_o stays 0x55 throughout; 0x66 follows after the pop.
- Flush: with usage_o=3, assert flush_i one cycle with inp_valid_i=1 → inp_ready_o=0 that cycle, usage_o=0 and oup_valid_o=0 next cycle, flushed words never appear.
- Fall-through (FALL_THROUGH=1): empty FIFO, inp_valid_i=1, data 0x7E, oup_ready_i=1 → oup_valid_o=1 and oup_data_o=0x7E in the same cycle, usage_o stays 0.
